// File: rtl/regfile_seq_if.sv
// Request handshake plus register-array/ALU control bus for the register-file sequencer.
// master = instruction decoder / ALU side, slave = the sequencer itself.
interface regfile_seq_if #(
    parameter int NREGS = 8,
    parameter int AW    = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_rs;
    logic [AW-1:0]    req_rt;
    logic [AW-1:0]    req_rd;
    logic             req_wb;
    logic [NREGS-1:0] selA;
    logic [NREGS-1:0] selB;
    logic [NREGS-1:0] en;
    logic             alu_start;
    logic             alu_done;
    logic             done;
    logic             err;
    logic             busy;

    modport master (
        output req_valid, req_rs, req_rt, req_rd, req_wb, alu_done,
        input  req_ready, selA, selB, en, alu_start, done, err, busy
    );

    modport slave (
        input  req_valid, req_rs, req_rt, req_rd, req_wb, alu_done,
        output req_ready, selA, selB, en, alu_start, done, err, busy
    );
endinterface

// File: rtl/regfile_seq.sv
// Register-file sequencer: one rs/rt/rd transfer at a time, READ -> EXEC (wait ALU) -> WRITE.
// Every output is a flop decoded from the next state and next latched fields.
module regfile_seq #(
    parameter int NREGS    = 8,
    parameter int AW       = 3,
    parameter int TIMEOUT  = 15,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [AW-1:0]    rs_reg, rs_next;
    logic [AW-1:0]    rt_reg, rt_next;
    logic [AW-1:0]    rd_reg, rd_next;
    logic             wb_reg, wb_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic             timeout_hit;

    logic             ready_reg, ready_next;
    logic             busy_reg, busy_next;
    logic             start_reg, start_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [NREGS-1:0] sela_reg, sela_next;
    logic [NREGS-1:0] selb_reg, selb_next;
    logic [NREGS-1:0] en_reg, en_next;

    logic [NREGS-1:0] rs_oh, rt_oh, rd_oh;
    logic             wr_block;

    // Addresses at or beyond NREGS match no bit and decode to all zeros.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_dec
            assign rs_oh[gi] = (rs_next == AW'(gi));
            assign rt_oh[gi] = (rt_next == AW'(gi));
            assign rd_oh[gi] = (rd_next == AW'(gi));
        end
    endgenerate

    assign wr_block = (ZERO_REG != 0) && (rd_next == '0);

    always_comb begin
        state_next  = state_reg;
        rs_next     = rs_reg;
        rt_next     = rt_reg;
        rd_next     = rd_reg;
        wb_next     = wb_reg;
        cnt_next    = cnt_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid && ready_reg) begin
                    rs_next    = bus.req_rs;
                    rt_next    = bus.req_rt;
                    rd_next    = bus.req_rd;
                    wb_next    = bus.req_wb;
                    state_next = READ;
                end
            end
            READ: begin
                cnt_next   = '0;
                state_next = EXEC;
            end
            EXEC: begin
                // alu_done takes priority over a timeout on the same cycle
                if (bus.alu_done) begin
                    cnt_next   = '0;
                    state_next = WRITE;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next    = '0;
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_next = (state_next == IDLE);
        busy_next  = (state_next != IDLE);
        start_next = (state_next == READ);
        done_next  = (state_next == WRITE);
        err_next   = timeout_hit;
        sela_next  = '0;
        selb_next  = '0;
        en_next    = '0;
        if (state_next == READ || state_next == EXEC) begin
            sela_next = rs_oh;
            selb_next = rt_oh;
        end
        if (state_next == WRITE && wb_next && !wr_block) begin
            en_next = rd_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            rs_reg    <= '0;
            rt_reg    <= '0;
            rd_reg    <= '0;
            wb_reg    <= 1'b0;
            cnt_reg   <= '0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            start_reg <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            sela_reg  <= '0;
            selb_reg  <= '0;
            en_reg    <= '0;
        end else begin
            state_reg <= state_next;
            rs_reg    <= rs_next;
            rt_reg    <= rt_next;
            rd_reg    <= rd_next;
            wb_reg    <= wb_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            start_reg <= start_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            sela_reg  <= sela_next;
            selb_reg  <= selb_next;
            en_reg    <= en_next;
        end
    end

    assign bus.req_ready = ready_reg;
    assign bus.busy      = busy_reg;
    assign bus.alu_start = start_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.selA      = sela_reg;
    assign bus.selB      = selb_reg;
    assign bus.en        = en_reg;
endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: two DUTs (ZERO_REG=1 and ZERO_REG=0) share one stimulus stream;
// a vector table feeds a scoreboard queue that a negedge monitor pops on done/err.
module tb_regfile_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_seq_if #(.NREGS(8), .AW(3)) bus1();
    regfile_seq_if #(.NREGS(8), .AW(3)) bus0();

    regfile_seq #(.NREGS(8), .AW(3), .TIMEOUT(15), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));
    regfile_seq #(.NREGS(8), .AW(3), .TIMEOUT(15), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));

    assign bus0.req_valid = bus1.req_valid;
    assign bus0.req_rs    = bus1.req_rs;
    assign bus0.req_rt    = bus1.req_rt;
    assign bus0.req_rd    = bus1.req_rd;
    assign bus0.req_wb    = bus1.req_wb;
    assign bus0.alu_done  = bus1.alu_done;

    // k = EXEC cycle (1-based) in which alu_done is raised, 0 = never (timeout).
    // exp_lat = rising edges after the acceptance edge until req_ready reads 1.
    typedef struct {
        int         id;
        logic [2:0] rs, rt, rd;
        logic       wb;
        int         k;
        bit         early;
        logic [7:0] exp_sela, exp_selb, exp_en1, exp_en0;
        logic       exp_done, exp_err;
        int         exp_lat;
    } vec_t;

    vec_t tbl[8];
    vec_t sb[$];
    vec_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [7:0] cap_sela = '0, cap_selb = '0, en_acc1 = '0, en_acc0 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus1.alu_start) begin
            cap_sela = bus1.selA;
            cap_selb = bus1.selB;
            en_acc1  = '0;
            en_acc0  = '0;
        end else if ((bus1.selA | bus1.selB) != 8'h00) begin
            chk("sel_hold_a", 32'(bus1.selA), 32'(cap_sela));
            chk("sel_hold_b", 32'(bus1.selB), 32'(cap_selb));
        end
        en_acc1 = en_acc1 | bus1.en;
        en_acc0 = en_acc0 | bus0.en;
        chk("bus_clash", 32'(bus1.en & (bus1.selA | bus1.selB)), 32'd0);
        if (bus1.done || bus1.err) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_completion: got done=%0b err=%0b, expected none",
                         bus1.done, bus1.err);
            end else begin
                mon_e = sb.pop_front();
                chk("done",  32'(bus1.done), 32'(mon_e.exp_done));
                chk("err",   32'(bus1.err),  32'(mon_e.exp_err));
                chk("done0", 32'(bus0.done), 32'(mon_e.exp_done));
                chk("err0",  32'(bus0.err),  32'(mon_e.exp_err));
                chk("en",    32'(en_acc1),   32'(mon_e.exp_en1));
                chk("en_z0", 32'(en_acc0),   32'(mon_e.exp_en0));
                chk("selA",  32'(cap_sela),  32'(mon_e.exp_sela));
                chk("selB",  32'(cap_selb),  32'(mon_e.exp_selb));
                $display("op %0d: selA=%02h selB=%02h en=%02h en(z0)=%02h done=%0b err=%0b",
                         mon_e.id, cap_sela, cap_selb, en_acc1, en_acc0, bus1.done, bus1.err);
            end
        end
    end

    // Called right after the acceptance edge; returns at the negedge where req_ready is back.
    task automatic finish_op(input vec_t v, input bit scramble);
        int m;
        bit got;
        m   = 0;
        got = 0;
        while (!got && m <= 40) begin
            @(negedge clk);
            if (m > 0 && bus1.req_ready === 1'b1) begin
                got = 1;
            end else begin
                if (m == 0) begin
                    chk("read_selA",  32'(bus1.selA), 32'(v.exp_sela));
                    chk("read_selB",  32'(bus1.selB), 32'(v.exp_selb));
                    chk("read_start", 32'(bus1.alu_start), 32'd1);
                    chk("read_ready", 32'(bus1.req_ready), 32'd0);
                    chk("read_busy",  32'(bus1.busy), 32'd1);
                end
                if (scramble) begin
                    bus1.req_rs = 3'($urandom_range(0, 7));
                    bus1.req_rt = 3'($urandom_range(0, 7));
                    bus1.req_rd = 3'($urandom_range(0, 7));
                    bus1.req_wb = 1'($urandom_range(0, 1));
                end else begin
                    bus1.req_valid = 1'b0;
                end
                bus1.alu_done = (v.k > 0 && m == v.k) || (v.early && m == 0);
                @(posedge clk);
                m++;
            end
        end
        bus1.alu_done = 1'b0;
        chk($sformatf("latency_op%0d", v.id), got ? 32'(m) : 32'd99, 32'(v.exp_lat));
    endtask

    task automatic drive_req(input vec_t v);
        bus1.req_rs    = v.rs;
        bus1.req_rt    = v.rt;
        bus1.req_rd    = v.rd;
        bus1.req_wb    = v.wb;
        bus1.req_valid = 1'b1;
        sb.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk("idle_ready", 32'(bus1.req_ready), 32'd1);
        drive_req(v);
        @(posedge clk);
        finish_op(v, 1'b0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus1.req_ready), 32'd1);
        chk({tag, "_busy"},  32'(bus1.busy),      32'd0);
        chk({tag, "_selA"},  32'(bus1.selA),      32'd0);
        chk({tag, "_selB"},  32'(bus1.selB),      32'd0);
        chk({tag, "_en"},    32'(bus1.en),        32'd0);
        chk({tag, "_en0"},   32'(bus0.en),        32'd0);
        chk({tag, "_start"}, 32'(bus1.alu_start), 32'd0);
        chk({tag, "_done"},  32'(bus1.done),      32'd0);
        chk({tag, "_err"},   32'(bus1.err),       32'd0);
    endtask

    initial begin
        vec_t ha, hb;
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ha, hb;
        rst            = 1'b0;
        bus1.req_valid = 1'b0;
        bus1.req_rs    = '0;
        bus1.req_rt    = '0;
        bus1.req_rd    = '0;
        bus1.req_wb    = 1'b0;
        bus1.alu_done  = 1'b0;

        //        id rs    rt    rd    wb    k   early selA   selB   en1    en0    done  err   lat
        tbl[0] = '{0, 3'd1, 3'd2, 3'd3, 1'b1, 1,  1'b0, 8'h02, 8'h04, 8'h08, 8'h08, 1'b1, 1'b0, 3};
        tbl[1] = '{1, 3'd4, 3'd6, 3'd5, 1'b0, 1,  1'b0, 8'h10, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0, 3};
        tbl[2] = '{2, 3'd7, 3'd7, 3'd0, 1'b1, 2,  1'b0, 8'h80, 8'h80, 8'h00, 8'h01, 1'b1, 1'b0, 4};
        tbl[3] = '{3, 3'd0, 3'd3, 3'd6, 1'b1, 0,  1'b0, 8'h01, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, 16};
        tbl[4] = '{4, 3'd5, 3'd1, 3'd7, 1'b1, 15, 1'b0, 8'h20, 8'h02, 8'h80, 8'h80, 1'b1, 1'b0, 17};
        tbl[5] = '{5, 3'd2, 3'd0, 3'd1, 1'b1, 3,  1'b1, 8'h04, 8'h01, 8'h02, 8'h02, 1'b1, 1'b0, 5};
        tbl[6] = '{6, 3'd6, 3'd5, 3'd2, 1'b1, 1,  1'b1, 8'h40, 8'h20, 8'h04, 8'h04, 1'b1, 1'b0, 3};
        tbl[7] = '{7, 3'd3, 3'd4, 3'd0, 1'b0, 1,  1'b0, 8'h08, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 3};
        ha     = '{8, 3'd1, 3'd6, 3'd4, 1'b1, 1,  1'b0, 8'h02, 8'h40, 8'h10, 8'h10, 1'b1, 1'b0, 3};
        hb     = '{9, 3'd5, 3'd2, 3'd3, 1'b1, 2,  1'b0, 8'h20, 8'h04, 8'h08, 8'h08, 1'b1, 1'b0, 4};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
        end

        // Hold req_valid with changing fields while busy; only the first request may show.
        @(negedge clk);
        drive_req(ha);
        @(posedge clk);
        finish_op(ha, 1'b1);
        drive_req(hb);
        @(posedge clk);
        finish_op(hb, 1'b0);

        // Reset on the same edge that alu_done is sampled in EXEC.
        @(negedge clk);
        bus1.req_rs    = 3'd2;
        bus1.req_rt    = 3'd3;
        bus1.req_rd    = 3'd4;
        bus1.req_wb    = 1'b1;
        bus1.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_exec_busy", 32'(bus1.busy), 32'd1);
        bus1.alu_done = 1'b1;
        rst           = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("midrst");
        rst           = 1'b1;
        bus1.alu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_en",    32'(bus1.en),        32'd0);
            chk("post_rst_done",  32'(bus1.done),      32'd0);
            chk("post_rst_ready", 32'(bus1.req_ready), 32'd1);
        end

        run_vec(tbl[0]);

        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
